// File: rtl/voice_allocator.sv
// Voice allocator: maps key-on/key-off events onto a pool of synth voices by sequential scan.
// Optional macro VOICE_STEAL_EN: steal the oldest HELD voice instead of dropping a key-on.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int KEY_W      = 4,
   parameter int AGE_W      = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        key_valid_i,
   output logic                        key_ready_o,
   input  logic                        key_on_i,
   input  logic [KEY_W-1:0]            key_code_i,
   input  logic [NUM_VOICES-1:0]       release_done_i,
   output logic [NUM_VOICES-1:0]       voice_gate_o,
   output logic [NUM_VOICES*KEY_W-1:0] voice_key_o,
   output logic [NUM_VOICES-1:0]       voice_trig_o,
   output logic                        drop_o
);
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`ifdef VOICE_STEAL_EN
   localparam bit STEAL_EN = 1'b1;
`else
   localparam bit STEAL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
   typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

   // Candidate rank, lower is better; NONE means no usable voice found yet
   localparam logic [2:0] R_MATCH = 3'd0;
   localparam logic [2:0] R_FREE  = 3'd1;
   localparam logic [2:0] R_REL   = 3'd2;
   localparam logic [2:0] R_HELD  = 3'd3;
   localparam logic [2:0] R_NONE  = 3'd4;

   state_t                state_q, state_d;
   vstate_t               vst_q [NUM_VOICES];
   vstate_t               vst_d [NUM_VOICES];
   logic [KEY_W-1:0]      vkey_q [NUM_VOICES];
   logic [KEY_W-1:0]      vkey_d [NUM_VOICES];
   logic [AGE_W-1:0]      age_q [NUM_VOICES];
   logic [AGE_W-1:0]      age_d [NUM_VOICES];
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      cand_idx_q, cand_idx_d;
   logic [2:0]            cand_rank_q, cand_rank_d;
   logic [AGE_W-1:0]      cand_age_q, cand_age_d;
   logic                  ev_on_q, ev_on_d;
   logic [KEY_W-1:0]      ev_code_q, ev_code_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic                  drop_q, drop_d;
   logic                  rdy_en_q, rdy_en_d;

   logic [2:0]            scan_rank;
   logic                  scan_better;

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (&a) ? a : a + AGE_W'(1);
   endfunction

   // Rank the voice under the scan pointer against the current best
   always_comb begin
      scan_rank = R_NONE;
      if (ev_on_q) begin
         if (vst_q[idx_q] != V_FREE && vkey_q[idx_q] == ev_code_q) scan_rank = R_MATCH;
         else if (vst_q[idx_q] == V_FREE)                          scan_rank = R_FREE;
         else if (vst_q[idx_q] == V_REL)                           scan_rank = R_REL;
         else                                                      scan_rank = R_HELD;
      end else if (vst_q[idx_q] == V_HELD && vkey_q[idx_q] == ev_code_q) begin
         scan_rank = R_MATCH;
      end
      scan_better = (scan_rank < cand_rank_q) ||
                    ((scan_rank == cand_rank_q) && (scan_rank == R_REL || scan_rank == R_HELD) &&
                     (age_q[idx_q] > cand_age_q));
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cand_idx_d  = cand_idx_q;
      cand_rank_d = cand_rank_q;
      cand_age_d  = cand_age_q;
      ev_on_d     = ev_on_q;
      ev_code_d   = ev_code_q;
      trig_d      = '0;
      drop_d      = 1'b0;
      rdy_en_d    = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++) begin
         vst_d[v]  = vst_q[v];
         vkey_d[v] = vkey_q[v];
         age_d[v]  = age_q[v];
         if (release_done_i[v] && vst_q[v] == V_REL) vst_d[v] = V_FREE;
      end

      case (state_q)
         S_IDLE: begin
            if (key_valid_i && key_ready_o) begin
               ev_on_d     = key_on_i;
               ev_code_d   = key_code_i;
               idx_d       = '0;
               cand_idx_d  = '0;
               cand_rank_d = R_NONE;
               cand_age_d  = '0;
               state_d     = S_SCAN;
            end
         end
         S_SCAN: begin
            if (scan_better) begin
               cand_idx_d  = idx_q;
               cand_rank_d = scan_rank;
               cand_age_d  = age_q[idx_q];
            end
            if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = S_COMMIT;
            else                                 idx_d   = idx_q + IDX_W'(1);
         end
         S_COMMIT: begin
            state_d = S_IDLE;
            // Commit assignments come last so they override a same-cycle release_done
            if (ev_on_q) begin
               if (cand_rank_q == R_HELD && !STEAL_EN) begin
                  drop_d = 1'b1;
               end else if (cand_rank_q != R_NONE) begin
                  for (int v = 0; v < NUM_VOICES; v++) begin
                     if (IDX_W'(v) == cand_idx_q) begin
                        vst_d[v]  = V_HELD;
                        vkey_d[v] = ev_code_q;
                        age_d[v]  = '0;
                        trig_d[v] = 1'b1;
                     end else if (vst_q[v] != V_FREE) begin
                        age_d[v]  = age_inc(age_q[v]);
                     end
                  end
               end
            end else if (cand_rank_q == R_MATCH) begin
               for (int v = 0; v < NUM_VOICES; v++)
                  if (IDX_W'(v) == cand_idx_q) vst_d[v] = V_REL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cand_idx_q  <= '0;
         cand_rank_q <= R_NONE;
         cand_age_q  <= '0;
         ev_on_q     <= 1'b0;
         ev_code_q   <= '0;
         trig_q      <= '0;
         drop_q      <= 1'b0;
         rdy_en_q    <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            vst_q[v]  <= V_FREE;
            vkey_q[v] <= '0;
            age_q[v]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cand_idx_q  <= cand_idx_d;
         cand_rank_q <= cand_rank_d;
         cand_age_q  <= cand_age_d;
         ev_on_q     <= ev_on_d;
         ev_code_q   <= ev_code_d;
         trig_q      <= trig_d;
         drop_q      <= drop_d;
         rdy_en_q    <= rdy_en_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            vst_q[v]  <= vst_d[v];
            vkey_q[v] <= vkey_d[v];
            age_q[v]  <= age_d[v];
         end
      end
   end

   // rdy_en_q holds ready low through reset and for the first cycle after it
   always_comb begin
      key_ready_o  = (state_q == S_IDLE) && rdy_en_q;
      voice_trig_o = trig_q;
      drop_o       = drop_q;
      voice_gate_o = '0;
      voice_key_o  = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_gate_o[v]                = (vst_q[v] == V_HELD);
         voice_key_o[v*KEY_W +: KEY_W]  = vkey_q[v];
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a behavioural voice-pool model feeding a scoreboard.
module tb_voice_allocator;
   localparam int NV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        key_on = 1'b0;
   logic [3:0]  key_code = '0;
   logic [3:0]  release_done = '0;
   logic [3:0]  gate;
   logic [15:0] vkey;
   logic [3:0]  trig;
   logic        drop;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  gate;
      logic [15:0] key;
      logic [3:0]  trig;
      logic        drop;
   } exp_t;
   exp_t sb[$];

   int         m_st  [NV];   // 0 free, 1 held, 2 releasing
   logic [3:0] m_key [NV];
   int         m_age [NV];

   voice_allocator #(.NUM_VOICES(NV), .KEY_W(4), .AGE_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_ready_o(key_ready),
      .key_on_i(key_on), .key_code_i(key_code), .release_done_i(release_done),
      .voice_gate_o(gate), .voice_key_o(vkey), .voice_trig_o(trig), .drop_o(drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_st[v] = 0; m_key[v] = '0; m_age[v] = 0;
      end
   endtask

   task automatic fill_exp(inout exp_t e);
      e.gate = '0; e.key = '0;
      for (int v = 0; v < NV; v++) begin
         e.gate[v] = (m_st[v] == 1);
         e.key[v*4 +: 4] = m_key[v];
      end
   endtask

   task automatic model_on(input logic [3:0] code, output exp_t e);
      int tgt = -1;
      e.trig = '0; e.drop = 1'b0;
      for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] != 0 && m_key[v] == code) tgt = v;
      for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] == 0) tgt = v;
      if (tgt < 0)
         for (int v = 0; v < NV; v++)
            if (m_st[v] == 2 && (tgt < 0 || m_age[v] > m_age[tgt])) tgt = v;
`ifdef VOICE_STEAL_EN
      if (tgt < 0)
         for (int v = 0; v < NV; v++)
            if (m_st[v] == 1 && (tgt < 0 || m_age[v] > m_age[tgt])) tgt = v;
`endif
      if (tgt < 0) begin
         e.drop = 1'b1;
      end else begin
         for (int v = 0; v < NV; v++) begin
            if (v == tgt) begin
               m_st[v] = 1; m_key[v] = code; m_age[v] = 0; e.trig[v] = 1'b1;
            end else if (m_st[v] != 0 && m_age[v] < 15) begin
               m_age[v]++;
            end
         end
      end
      fill_exp(e);
   endtask

   task automatic model_off(input logic [3:0] code, output exp_t e);
      int hit = 0;
      e.trig = '0; e.drop = 1'b0;
      for (int v = 0; v < NV; v++)
         if (hit == 0 && m_st[v] == 1 && m_key[v] == code) begin
            m_st[v] = 2; hit = 1;
         end
      fill_exp(e);
   endtask

   task automatic send_event(input logic on, input logic [3:0] code, input string tag);
      exp_t e;
      exp_t g;
      int w = 0;
      @(negedge clk);
      while (!key_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk($sformatf("%s_ready", tag), {31'd0, key_ready}, 32'd1);
      key_valid = 1'b1; key_on = on; key_code = code;
      if (on) model_on(code, e);
      else    model_off(code, e);
      sb.push_back(e);
      @(posedge clk); #1;
      key_valid = 1'b0; key_on = ~on; key_code = ~code;
      repeat (NV) @(posedge clk);
      #1;
      chk($sformatf("%s_trig_early", tag), {28'd0, trig}, 32'd0);
      @(posedge clk); #1;
      g = sb.pop_front();
      chk($sformatf("%s_gate", tag), {28'd0, gate}, {28'd0, g.gate});
      chk($sformatf("%s_key", tag),  {16'd0, vkey}, {16'd0, g.key});
      chk($sformatf("%s_trig", tag), {28'd0, trig}, {28'd0, g.trig});
      chk($sformatf("%s_drop", tag), {31'd0, drop}, {31'd0, g.drop});
      @(posedge clk); #1;
      chk($sformatf("%s_pulse_end", tag), {27'd0, drop, trig}, 32'd0);
   endtask

   task automatic rel_pulse(input logic [3:0] mask, input string tag);
      exp_t e;
      @(negedge clk);
      release_done = mask;
      for (int v = 0; v < NV; v++) if (mask[v] && m_st[v] == 2) m_st[v] = 0;
      @(posedge clk); #1;
      release_done = '0;
      e.trig = '0; e.drop = 1'b0;
      fill_exp(e);
      chk($sformatf("%s_gate", tag), {28'd0, gate}, {28'd0, e.gate});
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
   endtask

   initial begin
      model_reset();
      // Power-on reset: everything low, ready held low
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, key_ready}, 32'd0);
      chk("rst_outs", {gate, vkey, trig, 7'd0, drop}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready_after", {31'd0, key_ready}, 32'd1);

      send_event(1'b1, 4'd5, "on5");

      // Fill the pool, release code 2, then a new key reuses the releasing voice
      do_reset();
      send_event(1'b1, 4'd1, "fill1");
      send_event(1'b1, 4'd2, "fill2");
      send_event(1'b1, 4'd3, "fill3");
      send_event(1'b1, 4'd4, "fill4");
      send_event(1'b0, 4'd2, "off2");
      send_event(1'b1, 4'd9, "on9_reuse");

      // Two releasing voices; freeing the younger one must make it preferred
      send_event(1'b0, 4'd1, "off1");
      send_event(1'b0, 4'd9, "off9");
      rel_pulse(4'b0110, "reldone_v1_v2held");
      send_event(1'b1, 4'd7, "on7_free");

      // Full pool of HELD voices: steal or drop
      do_reset();
      send_event(1'b1, 4'd1, "full1");
      send_event(1'b1, 4'd2, "full2");
      send_event(1'b1, 4'd3, "full3");
      send_event(1'b1, 4'd4, "full4");
      send_event(1'b1, 4'd8, "on8_full");
      send_event(1'b0, 4'd6, "off6_nomatch");

      // Same key twice retriggers one voice
      do_reset();
      send_event(1'b1, 4'd3, "retrig_a");
      send_event(1'b1, 4'd3, "retrig_b");

      // Reset two cycles into a scan discards the event
      do_reset();
      @(negedge clk);
      key_valid = 1'b1; key_on = 1'b1; key_code = 4'hA;
      @(posedge clk); #1;
      key_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready", {31'd0, key_ready}, 32'd0);
      chk("midrst_outs", {gate, vkey, trig, 7'd0, drop}, 32'd0);
      @(posedge clk); #1;
      chk("midrst_trig", {28'd0, trig}, 32'd0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("midrst_ready_low", {31'd0, key_ready}, 32'd0);
      @(posedge clk); #1;
      chk("midrst_ready_up", {31'd0, key_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst_quiet%0d", i), {gate, vkey, trig, 7'd0, drop}, 32'd0);
      end
      model_reset();
      send_event(1'b1, 4'd5, "post_rst_on5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
